logic_gate_checker: RTL and testbench
=====================================

Name: logic_gate_checker

Overview:
Self-checking response monitor for the logic_gates block. It sits on the output side of the gate DUT. Each cycle it takes one stimulus pair (a, b) together with the seven gate outputs the DUT produced. It computes the expected results internally and compares them. It counts mismatches, captures the first failing vector, and reports a pass/fail verdict after a programmed number of vectors.

Parameters:
CNT_W, 8, width of the vector, error and index counters
NUM_VEC, 4, number of vectors accepted per run (range 1..2^CNT_W-1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a run (clears all results)
in_valid  input  1  a, b and the gate outputs are valid this cycle
in_ready  output  1  checker accepts a vector this cycle
a  input  1  stimulus operand a
b  input  1  stimulus operand b
and_gate  input  1  DUT AND output
or_gate  input  1  DUT OR output
not_gate  input  1  DUT NOT output (NOT of a)
nand_gate  input  1  DUT NAND output
nor_gate  input  1  DUT NOR output
xor_gate  input  1  DUT XOR output
xnor_gate  input  1  DUT XNOR output
busy  output  1  run in progress
done  output  1  run complete; verdict valid
pass  output  1  done and zero mismatches
vec_count  output  CNT_W  vectors accepted this run
err_count  output  CNT_W  vectors with at least one mismatching gate (saturating)
err_valid  output  1  first-error capture registers hold data
first_err_idx  output  CNT_W  zero-based index of the first failing vector
first_err_mask  output  7  per-gate mismatch bits of the first failing vector

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). On rst the checker enters IDLE and sets every output to 0.
- Expected outputs from the accepted a, b: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
- Mismatch mask bit order: [0] and, [1] or, [2] not, [3] nand, [4] nor, [5] xor, [6] xnor. A bit is 1 when the DUT output differs from the expected value.
- Accept condition: in_valid && in_ready, sampled at the rising edge.
- FSM states and transitions:
  - IDLE: in_ready=0, busy=0. If start=1: go to RUN and clear vec_count, err_count, err_valid, first_err_idx and first_err_mask.
  - RUN: in_ready=1, busy=1. On each accept, vec_count increments by 1. If the mask is non-zero, err_count increments by 1, saturating at all-ones. If the mask is non-zero and err_valid=0, latch first_err_idx = vec_count (pre-increment value), latch first_err_mask = mask, and set err_valid=1. Later failures never overwrite the capture. When the accept brings vec_count to NUM_VEC, go to DONE. start is ignored in RUN.
  - DONE: in_ready=0, busy=0, done=1, pass=(err_count==0). All results hold. start=1 clears the results and goes to RUN (same-cycle restart). in_valid is ignored.
- Latency: an accept at edge N is reflected in vec_count, err_count and the capture registers immediately after edge N. done/pass assert after the edge that accepts vector NUM_VEC-1 (zero-based).
- When in_valid=0 in RUN, nothing changes. Gaps of any length are legal.
- rst mid-run: aborts the run at the edge it is sampled. All outputs return to 0 and the FSM returns to IDLE. rst has priority over start and in_valid.
- X/Z on a gate input is not screened. The compare behaves as plain 2-state logic.
- pass is 0 whenever done=0.

Test Plan:
- Reset, start, then four correct vectors (a,b)=00,01,10,11 with correct outputs → after the 4th accept: done=1, pass=1, vec_count=4, err_count=0, err_valid=0.
- Same sequence with xor_gate forced to 0 on vector 01 → done=1, pass=0, err_count=1, first_err_idx=1, first_err_mask=7'b0100000.
- Errors on vectors 10 (not_gate wrong) and 11 (and_gate wrong) → err_count=2, first_err_idx=2, first_err_mask=7'b0000100 (the later failure is not captured).
- in_valid deasserted for 3 cycles between vectors, with garbage on the inputs during the gap → counters unchanged during the gap; final result identical to the first scenario.
- rst asserted after 2 accepts → next cycle all outputs are 0 and state is IDLE; a new start run of 4 correct vectors gives pass=1 and vec_count=4.
- CNT_W=2, NUM_VEC=3, every vector fails all gates → err_count=3 (all-ones, no overflow), first_err_mask=7'b1111111. A start pulse in DONE clears err_count to 0 and busy=1 the next cycle.

Source files
------------

// File: rtl/logic_gate_checker.sv
// rtl/logic_gate_checker.sv - response monitor that scores logic_gates outputs against a reference
module logic_gate_checker #(
    parameter int CNT_W   = 8,
    parameter int NUM_VEC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             and_gate,
    input  logic             or_gate,
    input  logic             not_gate,
    input  logic             nand_gate,
    input  logic             nor_gate,
    input  logic             xor_gate,
    input  logic             xnor_gate,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [6:0]       first_err_mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       clear;
    logic [6:0] expected;
    logic [6:0] observed;
    logic [6:0] mask;

    assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    assign observed = {xnor_gate, xor_gate, nor_gate, nand_gate, not_gate, or_gate, and_gate};
    assign mask     = expected ^ observed;

    assign accept = in_valid && in_ready;
    assign clear  = start && (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (accept && (vec_count == LAST_IDX)) state_next = ST_DONE;
            ST_DONE: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign pass = done && (err_count == '0);

    // Only the first failing vector is captured; err_valid locks it in.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_count      <= '0;
            err_count      <= '0;
            err_valid      <= 1'b0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
        end else if (accept) begin
            vec_count <= vec_count + 1'b1;
            if (mask != 7'd0) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!err_valid) begin
                    err_valid      <= 1'b1;
                    first_err_idx  <= vec_count;
                    first_err_mask <= mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_checker.sv
// tb/tb_logic_gate_checker.sv - directed self-checking bench for logic_gate_checker
module tb_logic_gate_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [6:0] g = 7'd0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       iv0 = 1'b0;
    logic       iv1 = 1'b0;

    logic       rdy0, busy0, done0, pass0, ev0;
    logic [7:0] vc0, ec0, fi0;
    logic [6:0] fm0;
    logic       rdy1, busy1, done1, pass1, ev1;
    logic [1:0] vc1, ec1, fi1;
    logic [6:0] fm1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_gate_checker #(.CNT_W(8), .NUM_VEC(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(iv0), .in_ready(rdy0),
        .a(a), .b(b),
        .and_gate(g[0]), .or_gate(g[1]), .not_gate(g[2]), .nand_gate(g[3]),
        .nor_gate(g[4]), .xor_gate(g[5]), .xnor_gate(g[6]),
        .busy(busy0), .done(done0), .pass(pass0), .vec_count(vc0), .err_count(ec0),
        .err_valid(ev0), .first_err_idx(fi0), .first_err_mask(fm0)
    );

    logic_gate_checker #(.CNT_W(2), .NUM_VEC(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(iv1), .in_ready(rdy1),
        .a(a), .b(b),
        .and_gate(g[0]), .or_gate(g[1]), .not_gate(g[2]), .nand_gate(g[3]),
        .nor_gate(g[4]), .xor_gate(g[5]), .xnor_gate(g[6]),
        .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .err_count(ec1),
        .err_valid(ev1), .first_err_idx(fi1), .first_err_mask(fm1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one vector for one edge; em flips the chosen gate outputs to fake a broken DUT.
    task automatic send(input logic [1:0] ab, input logic [6:0] em, input bit sel);
        logic [6:0] ref_out;
        a = ab[1];
        b = ab[0];
        ref_out = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        g = ref_out ^ em;
        if (sel) iv1 = 1'b1; else iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        iv1 = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            g = 7'($urandom);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_ready", rdy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_vec", vc0, 0);
        chk("rst_err", ec0, 0);
        chk("rst_ev", ev0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_accept", rdy0, 0);

        // All-correct run
        pulse_start(0);
        chk("run_busy", busy0, 1);
        chk("run_ready", rdy0, 1);
        send(2'b00, 7'd0, 0);
        send(2'b01, 7'd0, 0);
        chk("mid_vec", vc0, 2);
        pulse_start(0);
        chk("start_ignored_run", vc0, 2);
        send(2'b10, 7'd0, 0);
        chk("not_done_at_3", done0, 0);
        send(2'b11, 7'd0, 0);
        chk("s1_done", done0, 1);
        chk("s1_pass", pass0, 1);
        chk("s1_vec", vc0, 4);
        chk("s1_err", ec0, 0);
        chk("s1_ev", ev0, 0);
        chk("s1_busy", busy0, 0);
        send(2'b00, 7'h7f, 0);
        chk("done_ignores_valid", {vc0, ec0}, {8'd4, 8'd0});

        // xor_gate stuck 0 on vector 01
        pulse_start(0);
        chk("restart_clear", {vc0, done0, pass0}, {8'd0, 1'b0, 1'b0});
        chk("restart_busy", busy0, 1);
        send(2'b00, 7'd0, 0);
        send(2'b01, 7'b0100000, 0);
        chk("s2_ev_early", {ev0, fi0, 1'b0, fm0}, {1'b1, 8'd1, 1'b0, 7'b0100000});
        send(2'b10, 7'd0, 0);
        send(2'b11, 7'd0, 0);
        chk("s2_done", done0, 1);
        chk("s2_pass", pass0, 0);
        chk("s2_err", ec0, 1);
        chk("s2_idx", fi0, 1);
        chk("s2_mask", fm0, 7'b0100000);

        // Two failures; only the first is captured
        pulse_start(0);
        chk("s3_cleared", {ev0, fi0, ec0, 1'b0, fm0}, 32'd0);
        send(2'b00, 7'd0, 0);
        send(2'b01, 7'd0, 0);
        send(2'b10, 7'b0000100, 0);
        send(2'b11, 7'b0000001, 0);
        chk("s3_err", ec0, 2);
        chk("s3_idx", fi0, 2);
        chk("s3_mask", fm0, 7'b0000100);
        chk("s3_pass", pass0, 0);

        // Gaps with garbage
        pulse_start(0);
        send(2'b00, 7'd0, 0);
        gap(3);
        chk("gap_vec", vc0, 1);
        chk("gap_err", ec0, 0);
        send(2'b01, 7'd0, 0);
        gap(3);
        send(2'b10, 7'd0, 0);
        gap(3);
        chk("gap_vec3", vc0, 3);
        send(2'b11, 7'd0, 0);
        chk("s4_result", {done0, pass0, ev0, vc0, ec0}, {1'b1, 1'b1, 1'b0, 8'd4, 8'd0});

        // Reset mid-run
        pulse_start(0);
        send(2'b00, 7'd0, 0);
        send(2'b01, 7'h01, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_outs", {busy0, rdy0, done0, pass0, ev0}, 5'd0);
        chk("midrst_cnt", {vc0, ec0, fi0, 1'b0, fm0}, 32'd0);
        send(2'b11, 7'd0, 0);
        chk("midrst_idle_noacc", vc0, 0);
        pulse_start(0);
        send(2'b00, 7'd0, 0);
        send(2'b01, 7'd0, 0);
        send(2'b10, 7'd0, 0);
        send(2'b11, 7'd0, 0);
        chk("s5_pass", {done0, pass0, vc0}, {1'b1, 1'b1, 8'd4});

        // Narrow counters, every gate wrong
        pulse_start(1);
        send(2'b00, 7'h7f, 1);
        send(2'b01, 7'h7f, 1);
        chk("s6_not_done", done1, 0);
        send(2'b11, 7'h7f, 1);
        chk("s6_done", done1, 1);
        chk("s6_pass", pass1, 0);
        chk("s6_err", ec1, 3);
        chk("s6_vec", vc1, 3);
        chk("s6_idx", fi1, 0);
        chk("s6_mask", fm1, 7'h7f);
        pulse_start(1);
        chk("s6_restart_err", ec1, 0);
        chk("s6_restart_busy", busy1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
